// File: rtl/fetch_pc.sv
// Fetch-stage program counter: next-PC selection (jr > j > taken branch > PC+4),
// stall hold, redirect flag and sticky address-error flag. Optional branch
// statistics counters are enabled with the FETCH_PC_BRANCH_STATS_EN macro.
module fetch_pc #(
  parameter logic [31:0] RESET_PC = 32'h0000_3000,
  parameter int          IM_WORDS = 4096
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        FPC_i_Stall,
  input  logic        FPC_i_BrValid,
  input  logic        FPC_i_CmpResult,
  input  logic [15:0] FPC_i_BrImm,
  input  logic [31:0] FPC_i_IdPC4,
  input  logic        FPC_i_JValid,
  input  logic [25:0] FPC_i_JIndex,
  input  logic        FPC_i_JrValid,
  input  logic [31:0] FPC_i_JrTarget,
  output logic [31:0] FPC_o_PC,
  output logic [31:0] FPC_o_PC4,
  output logic        FPC_o_Redirect,
  output logic        FPC_o_AddrErr
`ifdef FETCH_PC_BRANCH_STATS_EN
  ,
  output logic [15:0] FPC_o_BrTotal,
  output logic [15:0] FPC_o_BrTaken
`endif
);

  // Range bounds kept 33 bits wide so a RESET_PC near the top of memory cannot wrap.
  localparam logic [32:0] PC_FIRST = {1'b0, RESET_PC};
  localparam logic [32:0] PC_LAST  = PC_FIRST + 33'(4 * IM_WORDS) - 33'd4;

  function automatic logic pc_illegal(input logic [31:0] pc);
    logic [32:0] pc_w;
    pc_w = {1'b0, pc};
    return (pc[1:0] != 2'b00) || (pc_w < PC_FIRST) || (pc_w > PC_LAST);
  endfunction

  logic [31:0] pc_q, pc_d;
  logic        redir_q, redir_d;
  logic        err_q, err_d;
  logic [31:0] br_target_s;
  logic [31:0] j_target_s;
  logic [31:0] next_pc_s;
  logic        next_redir_s;

  // Next-PC selection and stall hold.
  always_comb begin
    br_target_s  = FPC_i_IdPC4 + {{14{FPC_i_BrImm[15]}}, FPC_i_BrImm, 2'b00};
    j_target_s   = {FPC_i_IdPC4[31:28], FPC_i_JIndex, 2'b00};
    next_pc_s    = pc_q + 32'd4;
    next_redir_s = 1'b0;
    if (FPC_i_JrValid) begin
      next_pc_s    = FPC_i_JrTarget;
      next_redir_s = 1'b1;
    end else if (FPC_i_JValid) begin
      next_pc_s    = j_target_s;
      next_redir_s = 1'b1;
    end else if (FPC_i_BrValid && FPC_i_CmpResult) begin
      next_pc_s    = br_target_s;
      next_redir_s = 1'b1;
    end else begin
      next_pc_s    = pc_q + 32'd4;
      next_redir_s = 1'b0;
    end

    pc_d    = pc_q;
    redir_d = redir_q;
    err_d   = err_q;
    if (!FPC_i_Stall) begin
      pc_d    = next_pc_s;
      redir_d = next_redir_s;
      err_d   = err_q | pc_illegal(next_pc_s);
    end else begin
      pc_d    = pc_q;
      redir_d = redir_q;
      err_d   = err_q;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      pc_q    <= RESET_PC;
      redir_q <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      pc_q    <= pc_d;
      redir_q <= redir_d;
      err_q   <= err_d;
    end
  end

  assign FPC_o_PC       = pc_q;
  assign FPC_o_PC4      = pc_q + 32'd4;
  assign FPC_o_Redirect = redir_q;
  assign FPC_o_AddrErr  = err_q;

`ifdef FETCH_PC_BRANCH_STATS_EN
  logic [15:0] br_total_q, br_total_d;
  logic [15:0] br_taken_q, br_taken_d;

  // Saturating branch counters; stalled cycles re-present the same branch and are not counted.
  always_comb begin
    br_total_d = br_total_q;
    br_taken_d = br_taken_q;
    if (!FPC_i_Stall && FPC_i_BrValid) begin
      if (br_total_q != 16'hFFFF) begin
        br_total_d = br_total_q + 16'd1;
      end else begin
        br_total_d = br_total_q;
      end
      if (FPC_i_CmpResult && (br_taken_q != 16'hFFFF)) begin
        br_taken_d = br_taken_q + 16'd1;
      end else begin
        br_taken_d = br_taken_q;
      end
    end else begin
      br_total_d = br_total_q;
      br_taken_d = br_taken_q;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      br_total_q <= 16'd0;
      br_taken_q <= 16'd0;
    end else begin
      br_total_q <= br_total_d;
      br_taken_q <= br_taken_d;
    end
  end

  assign FPC_o_BrTotal = br_total_q;
  assign FPC_o_BrTaken = br_taken_q;
`endif

endmodule

// File: tb/tb_fetch_pc.sv
// Self-checking bench for fetch_pc: directed vectors followed by randomized
// stimulus, all checked against a behavioural next-PC model.
module tb_fetch_pc;

  localparam logic [31:0] RST_PC = 32'h0000_3000;
  localparam int          IMW    = 4096;

  logic        clk = 1'b0;
  logic        reset;
  logic        stall, br_valid, cmp, j_valid, jr_valid;
  logic [15:0] br_imm;
  logic [31:0] id_pc4, jr_target;
  logic [25:0] j_index;
  logic [31:0] pc, pc4;
  logic        redirect, addr_err;
`ifdef FETCH_PC_BRANCH_STATS_EN
  logic [15:0] br_total, br_taken;
`endif

  int compared   = 0;
  int mismatched = 0;

  // Behavioural model state
  logic [31:0] m_pc;
  logic        m_redir, m_err;
  int          m_tot, m_tak;

  fetch_pc #(.RESET_PC(RST_PC), .IM_WORDS(IMW)) dut (
    .clk            (clk),
    .reset          (reset),
    .FPC_i_Stall    (stall),
    .FPC_i_BrValid  (br_valid),
    .FPC_i_CmpResult(cmp),
    .FPC_i_BrImm    (br_imm),
    .FPC_i_IdPC4    (id_pc4),
    .FPC_i_JValid   (j_valid),
    .FPC_i_JIndex   (j_index),
    .FPC_i_JrValid  (jr_valid),
    .FPC_i_JrTarget (jr_target),
    .FPC_o_PC       (pc),
    .FPC_o_PC4      (pc4),
    .FPC_o_Redirect (redirect),
    .FPC_o_AddrErr  (addr_err)
`ifdef FETCH_PC_BRANCH_STATS_EN
    ,
    .FPC_o_BrTotal  (br_total),
    .FPC_o_BrTaken  (br_taken)
`endif
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic bit legal(input logic [31:0] a);
    longint v;
    v = longint'(a);
    return (v % 4 == 0) && (v >= longint'(RST_PC)) && (v <= longint'(RST_PC) + 4 * IMW - 4);
  endfunction

  task automatic clear_inputs();
    stall = 1'b0; br_valid = 1'b0; cmp = 1'b0; j_valid = 1'b0; jr_valid = 1'b0;
    br_imm = 16'h0000; id_pc4 = 32'h0; jr_target = 32'h0; j_index = 26'h0;
  endtask

  // Advance one clock: update the model from the driven inputs, then compare.
  task automatic tick(input string tag);
    logic [31:0] nxt;
    longint      t;
    bit          rd;
    if (reset) begin
      m_pc = RST_PC; m_redir = 1'b0; m_err = 1'b0; m_tot = 0; m_tak = 0;
    end else if (!stall) begin
      rd = 1'b1;
      if (jr_valid) nxt = jr_target;
      else if (j_valid) nxt = (id_pc4 & 32'hF000_0000) | (32'(j_index) * 32'd4);
      else if (br_valid && cmp) begin
        t   = longint'(id_pc4) + 4 * longint'($signed(br_imm));
        nxt = 32'(t);
      end else begin
        nxt = 32'(longint'(m_pc) + 4);
        rd  = 1'b0;
      end
      m_pc    = nxt;
      m_redir = rd;
      if (!legal(nxt)) m_err = 1'b1;
      if (br_valid) begin
        if (m_tot < 65535) m_tot++;
        if (cmp && m_tak < 65535) m_tak++;
      end
    end
    @(posedge clk);
    #1;
    check({tag, ".pc"}, pc, m_pc);
    check({tag, ".pc4"}, pc4, m_pc + 32'd4);
    check({tag, ".redirect"}, {31'd0, redirect}, {31'd0, m_redir});
    check({tag, ".addrerr"}, {31'd0, addr_err}, {31'd0, m_err});
`ifdef FETCH_PC_BRANCH_STATS_EN
    check({tag, ".brtotal"}, {16'd0, br_total}, 32'(m_tot));
    check({tag, ".brtaken"}, {16'd0, br_taken}, 32'(m_tak));
`endif
  endtask

  initial begin
    clear_inputs();
    reset = 1'b1;
    m_pc = 32'h0; m_redir = 1'b0; m_err = 1'b0; m_tot = 0; m_tak = 0;

    // Reset overrides stall and redirects presented in the same cycle
    stall = 1'b1; jr_valid = 1'b1; jr_target = 32'h0000_3400; j_valid = 1'b1;
    tick("reset");
    check("reset.pc_const", pc, 32'h0000_3000);
    clear_inputs();
    reset = 1'b0;

    tick("free1"); check("free1.const", pc, 32'h0000_3004);
    tick("free2"); check("free2.const", pc, 32'h0000_3008);
    tick("free3"); check("free3.const", pc, 32'h0000_300C);

    // Taken backward branch, then the same branch not taken
    br_valid = 1'b1; cmp = 1'b1; id_pc4 = 32'h0000_3010; br_imm = 16'hFFFC;
    tick("br_taken"); check("br_taken.const", pc, 32'h0000_3000);
    cmp = 1'b0;
    tick("br_not_taken"); check("br_not_taken.const", pc, 32'h0000_3004);
    clear_inputs();

    // jr beats j
    jr_valid = 1'b1; jr_target = 32'h0000_3400; j_valid = 1'b1; j_index = 26'h0000D00;
    id_pc4 = 32'h0000_3010;
    tick("jr_wins"); check("jr_wins.const", pc, 32'h0000_3400);
    clear_inputs();
    tick("post_jr");

    // Stall holds for two cycles while a jump waits, then the jump lands
    stall = 1'b1; j_valid = 1'b1; j_index = 26'h0000D40; id_pc4 = 32'h0000_3010;
    tick("stall1");
    tick("stall2");
    stall = 1'b0;
    tick("jump_after_stall"); check("jump_after_stall.const", pc, 32'h0000_3500);
    clear_inputs();

    // Misaligned jr target latches a sticky address error
    jr_valid = 1'b1; jr_target = 32'h0000_3002;
    tick("misaligned"); check("misaligned.err_const", {31'd0, addr_err}, 32'd1);
    jr_target = 32'h0000_3100;
    tick("legal_after_err");
    clear_inputs();
    tick("seq_after_err");
    reset = 1'b1; tick("reset2"); reset = 1'b0;

    // Sequential wrap at the top of the address space
    jr_valid = 1'b1; jr_target = 32'hFFFF_FFFC;
    tick("top");
    clear_inputs();
    tick("wrap"); check("wrap.const", pc, 32'h0000_0000);
    // Reset in the same cycle as a redirect discards the redirect
    reset = 1'b1; jr_valid = 1'b1; jr_target = 32'h0000_3200;
    tick("reset_mid_redirect");
    clear_inputs(); reset = 1'b0;

    // Branch statistics: six presentations, one stalled; five counted, three taken
    br_valid = 1'b1; id_pc4 = 32'h0000_3020; br_imm = 16'h0004;
    cmp = 1'b1; tick("bs1");
    cmp = 1'b0; tick("bs2");
    stall = 1'b1; cmp = 1'b1; tick("bs_stalled");
    stall = 1'b0; tick("bs3");
    cmp = 1'b0; tick("bs4");
    cmp = 1'b1; tick("bs5");
    clear_inputs();
`ifdef FETCH_PC_BRANCH_STATS_EN
    check("stats.total_const", {16'd0, br_total}, 32'd5);
    check("stats.taken_const", {16'd0, br_taken}, 32'd3);
`endif

    // Randomized stimulus
    for (int i = 0; i < 400; i++) begin
      reset     = ($urandom_range(0, 39) == 0);
      stall     = ($urandom_range(0, 3) == 0);
      jr_valid  = ($urandom_range(0, 7) == 0);
      j_valid   = ($urandom_range(0, 7) == 0);
      br_valid  = ($urandom_range(0, 2) == 0);
      cmp       = $urandom_range(0, 1) == 1;
      br_imm    = 16'($urandom);
      id_pc4    = RST_PC + 32'($urandom_range(1, IMW)) * 32'd4;
      j_index   = 26'($urandom);
      jr_target = ($urandom_range(0, 4) == 0) ? 32'($urandom)
                                              : RST_PC + 32'($urandom_range(0, IMW - 1)) * 32'd4;
      tick("random");
    end
    clear_inputs();
    reset = 1'b0;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
